// File: rtl/parametrik_evrisim_birimi.sv
// parametrik_evrisim_birimi
// Streaming 3x3 convolution over one raster-order frame with zero padding at
// the borders. One output per input pixel; after the last pixel the block
// drains itself with GENISLIK+1 internal zero beats.
//
// Ports
//   clk_i, rstn_i      clock (rising edge), asynchronous active-low reset
//   filtre_etkin_i     latch filtre_i / kaydirma_i / mod_i (only while idle)
//   filtre_i           k0..k8, k0 in the MSBs, row-major, signed
//   kaydirma_i         arithmetic right shift applied to the sum
//   mod_i              0: clamp signed result, 1: |x| then clamp
//   veri_etkin_i/veri_i     input pixel stream
//   veri_etkin_o/veri_o     output pixel stream
//   mesgul_o           draining, inputs ignored
//   cerceve_bitti_o    pulse with the last output of the frame
//
// state  | meaning
// BOS    | idle, no pixel of the frame accepted yet, filter load allowed
// AKIS   | streaming pixels of the current frame
// BOSALT | draining with zero beats, mesgul_o high
module parametrik_evrisim_birimi #(
    parameter int GENISLIK    = 320,
    parameter int YUKSEKLIK   = 240,
    parameter int VERI_BIT    = 8,
    parameter int KATSAYI_BIT = 8
) (
    input  logic                     clk_i,
    input  logic                     rstn_i,
    input  logic                     filtre_etkin_i,
    input  logic [9*KATSAYI_BIT-1:0] filtre_i,
    input  logic [3:0]               kaydirma_i,
    input  logic                     mod_i,
    input  logic                     veri_etkin_i,
    input  logic [VERI_BIT-1:0]      veri_i,
    output logic                     veri_etkin_o,
    output logic [VERI_BIT-1:0]      veri_o,
    output logic                     mesgul_o,
    output logic                     cerceve_bitti_o
);
    localparam int CW = (GENISLIK > 1) ? $clog2(GENISLIK) : 1;
    localparam int RW = $clog2(YUKSEKLIK + 2);
    localparam int PW = VERI_BIT + KATSAYI_BIT + 1;
    localparam int SW = PW + 4;
    localparam logic [CW-1:0] SUTUN_SON = CW'(GENISLIK - 1);
    localparam logic [RW-1:0] SATIR_SON = RW'(YUKSEKLIK - 1);
    localparam logic [RW-1:0] SATIR_H   = RW'(YUKSEKLIK);
    localparam logic [RW-1:0] SATIR_H1  = RW'(YUKSEKLIK + 1);
    localparam logic signed [SW-1:0] UST_SINIR = SW'((1 << VERI_BIT) - 1);

    typedef enum logic [1:0] {BOS, AKIS, BOSALT} durum_t;

    durum_t durum, durum_sonraki;

    logic signed [KATSAYI_BIT-1:0] katsayi [9];
    logic [3:0]                    kaydirma_q;
    logic                          mod_q;

    logic [RW-1:0]       satir;
    logic [CW-1:0]       sutun;
    logic                kabul, bosalt_vurus, vurus, cikis_var;
    logic [VERI_BIT-1:0] giris;

    logic [VERI_BIT-1:0] hat1 [GENISLIK];
    logic [VERI_BIT-1:0] hat2 [GENISLIK];
    logic [VERI_BIT-1:0] pencere [3][3];

    logic gecerli1, son1, ust1, alt1, sol1, sag1;
    logic gecerli2, son2;
    logic signed [PW-1:0] carpim [9];

    logic signed [SW-1:0] toplam, kaydirilmis;
    logic [VERI_BIT-1:0]  sonuc;

    // A beat is either an accepted pixel or a drain beat; both advance the
    // counters, line buffers and window identically.
    assign kabul        = veri_etkin_i && (durum != BOSALT);
    assign bosalt_vurus = (durum == BOSALT) && (satir != '0);
    assign vurus        = kabul || bosalt_vurus;
    assign giris        = bosalt_vurus ? '0 : veri_i;
    // The first GENISLIK+1 beats of a frame only fill the window.
    assign cikis_var    = (satir >= RW'(2)) || ((satir == RW'(1)) && (sutun != '0));

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) durum <= BOS;
        else         durum <= durum_sonraki;
    end

    always_comb begin
        durum_sonraki = durum;
        case (durum)
            BOS:    if (veri_etkin_i) durum_sonraki = AKIS;
            AKIS:   if (kabul && satir == SATIR_SON && sutun == SUTUN_SON)
                        durum_sonraki = BOSALT;
            BOSALT: if (cerceve_bitti_o) durum_sonraki = BOS;
            default: durum_sonraki = BOS;
        endcase
    end

    always_comb begin
        mesgul_o = (durum == BOSALT);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < 9; i++) katsayi[i] <= '0;
            kaydirma_q <= '0;
            mod_q      <= 1'b0;
        end else if (durum == BOS && filtre_etkin_i) begin
            for (int i = 0; i < 9; i++)
                katsayi[i] <= filtre_i[(8-i)*KATSAYI_BIT +: KATSAYI_BIT];
            kaydirma_q <= kaydirma_i;
            mod_q      <= mod_i;
        end
    end

    // Counters run over GENISLIK*YUKSEKLIK pixels plus GENISLIK+1 drain
    // beats; the final drain beat sits at (YUKSEKLIK+1, 0).
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            satir <= '0;
            sutun <= '0;
        end else if (vurus) begin
            if (satir == SATIR_H1) begin
                satir <= '0;
                sutun <= '0;
            end else if (sutun == SUTUN_SON) begin
                sutun <= '0;
                satir <= satir + RW'(1);
            end else begin
                sutun <= sutun + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (vurus) begin
            hat1[sutun] <= giris;
            hat2[sutun] <= hat1[sutun];
            for (int r = 0; r < 3; r++) begin
                pencere[r][0] <= pencere[r][1];
                pencere[r][1] <= pencere[r][2];
            end
            pencere[0][2] <= hat2[sutun];
            pencere[1][2] <= hat1[sutun];
            pencere[2][2] <= giris;
        end
    end

    // Border masks for the window centre. On a column-0 beat the centre is
    // the last column of the row two above, so the newest window column
    // belongs to the next row group and is masked as right padding.
    // Masking also hides stale line-buffer and window contents.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gecerli1 <= 1'b0;
            son1     <= 1'b0;
            ust1     <= 1'b0;
            alt1     <= 1'b0;
            sol1     <= 1'b0;
            sag1     <= 1'b0;
        end else begin
            gecerli1 <= vurus && cikis_var;
            if (vurus) begin
                ust1 <= (sutun != '0) ? (satir == RW'(1)) : (satir == RW'(2));
                alt1 <= (sutun != '0) ? (satir == SATIR_H) : (satir == SATIR_H1);
                sol1 <= (sutun == CW'(1));
                sag1 <= (sutun == '0);
                son1 <= (satir == SATIR_H1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            gecerli2 <= 1'b0;
            son2     <= 1'b0;
        end else begin
            gecerli2 <= gecerli1;
            son2     <= son1;
        end
    end

    always_ff @(posedge clk_i) begin
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if ((r == 0 && ust1) || (r == 2 && alt1) || (c == 0 && sol1) || (c == 2 && sag1))
                    carpim[r*3+c] <= '0;
                else
                    carpim[r*3+c] <= $signed({1'b0, pencere[r][c]}) * katsayi[r*3+c];
            end
        end
    end

    always_comb begin
        toplam = '0;
        for (int i = 0; i < 9; i++) toplam = toplam + SW'(carpim[i]);
        kaydirilmis = toplam >>> kaydirma_q;
        if (mod_q && kaydirilmis[SW-1]) kaydirilmis = -kaydirilmis;
        if (kaydirilmis[SW-1])             sonuc = '0;
        else if (kaydirilmis > UST_SINIR)  sonuc = '1;
        else                               sonuc = kaydirilmis[VERI_BIT-1:0];
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            veri_etkin_o    <= 1'b0;
            veri_o          <= '0;
            cerceve_bitti_o <= 1'b0;
        end else begin
            veri_etkin_o    <= gecerli2;
            cerceve_bitti_o <= gecerli2 && son2;
            if (gecerli2) veri_o <= sonuc;
        end
    end
endmodule

// File: doc/parametrik_evrisim_birimi.md
# parametrik_evrisim_birimi

Streaming 3x3 convolution unit, parametrised in image size and sample/coefficient width, with runtime-selectable output shift and output mode. It is the next generation of `evrisim_birimi`. It sits between the pixel source and the result sink in the image pipeline. It consumes one raster-order frame and emits exactly one output per input pixel, with zero padding at the borders. After the last input pixel it drains itself automatically.

## Interface
- GENISLIK, 320: pixels per row (≥3)
- YUKSEKLIK, 240: rows per frame (≥2)
- VERI_BIT, 8: unsigned pixel width, in and out
- KATSAYI_BIT, 8: signed coefficient width
- clk_i  in  1  clock, all logic on rising edge
- rstn_i  in  1  reset, asynchronous, active-low
- filtre_etkin_i  in  1  load strobe for filtre_i/kaydirma_i/mod_i
- filtre_i  in  9*KATSAYI_BIT  coefficients k0..k8, k0 in MSBs. Row-major, k0 = (row-1,col-1), k4 = centre, k8 = (row+1,col+1)
- kaydirma_i  in  4  arithmetic right-shift applied to the sum
- mod_i  in  1  0: clamp signed result; 1: absolute value, then clamp
- veri_etkin_i  in  1  input pixel valid
- veri_i  in  VERI_BIT  input pixel
- veri_etkin_o  out  1  output pixel valid (single-cycle per pixel)
- veri_o  out  VERI_BIT  output pixel
- mesgul_o  out  1  draining; inputs ignored
- cerceve_bitti_o  out  1  one-cycle pulse coincident with the frame's last output

## Operation
- Two line buffers of GENISLIK×VERI_BIT plus a 3x3 window register. Row and column counters track the input position.
- Zero padding:
  - Window taps outside the image (row -1, row YUKSEKLIK, col -1, col GENISLIK) read as 0.
  - No wrap-around: column 0 never sees the previous row's last pixels.
  - Line buffer contents left over from previous frames never leak into the output.
- Output for pixel (r,c) is computed once input (r+1,c+1) has been accepted, or its flush equivalent.
- Arithmetic:
  - Each product is unsigned VERI_BIT × signed KATSAYI_BIT, held at VERI_BIT+KATSAYI_BIT+1 signed bits.
  - The sum of 9 products adds 4 guard bits. No overflow is possible.
  - The sum is shifted right arithmetically by kaydirma_i.
  - mod 0: clamp to [0, 2^VERI_BIT-1].
  - mod 1: take |x|, then clamp to 2^VERI_BIT-1.
- Filter load:
  - On filtre_etkin_i, the block latches filtre_i, kaydirma_i and mod_i.
  - The load is honoured only while no pixel of the current frame has been accepted. This includes the same cycle as the frame's first pixel, and that load applies to that frame.
  - Loads during a frame or while draining are ignored.
- States:
  - BOS: idle, no pixel of the frame accepted yet.
  - AKIS: streaming; moves to BOS-equivalent frame start after drain.
  - BOSALT: draining; mesgul_o is high in this state.
- Transitions:
  - BOS→AKIS on the first accepted pixel.
  - AKIS→BOSALT the cycle after pixel (YUKSEKLIK-1, GENISLIK-1) is accepted.
  - BOSALT generates GENISLIK+1 internal flush beats, one per cycle. Flush beats use zero data and advance the window like real pixels.
  - BOSALT→BOS after the final output is emitted.
- veri_etkin_i while mesgul_o is high is ignored; the pixel is not consumed and not counted.

## Timing
- Reset values: veri_etkin_o=0, veri_o=0, mesgul_o=0, cerceve_bitti_o=0. Coefficients, shift and mode = 0. Counters = 0, state BOS.
- Reset is asynchronous. Assertion mid-frame aborts the frame immediately, and outputs go to reset values at once. Line buffers need not be cleared.
- Pipeline: window update cycle → product register → sum/shift/clamp register → output.
- With a gap-free input stream, output (r,c) appears GENISLIK+3 cycles after pixel (r,c) is accepted.
- Input gaps stall the window and do not change values or order. Outputs are strictly raster order.
- Drain: mesgul_o rises the cycle after the last pixel is accepted. The final output arrives GENISLIK+3 cycles after the last pixel. mesgul_o falls the cycle after that final output.
- The next frame's first pixel may be presented on the cycle mesgul_o falls.
- Exactly GENISLIK×YUKSEKLIK outputs are produced per frame.

## Test plan
All scenarios use GENISLIK=4, YUKSEKLIK=3.
- Identity: filter {0,0,0,0,1,0,0,0,0}, shift 0, mode 0, input ramp 0..11 gap-free → outputs 0..11 in order. First output 7 cycles after pixel 0. cerceve_bitti_o coincides with output 11. Exactly 12 valids.
- Sobel-x {-1,0,1,-2,0,2,-1,0,1}, mode 1, constant-100 image:
  - cols 1–2 → 0.
  - col 0 and col 3, middle row → 255 (|±400| clamped).
  - col 0 and col 3, top/bottom rows → 255 (|±300| clamped).
  - Same filter in mode 0: col 3 → 0 everywhere.
- Box filter (all 1), shift 3, constant-255 image → corners 127 (1020>>3), edges 191 (1530>>3), interior 255 (286 clamped).
- Gappy input: identity filter, veri_etkin_i toggling every other cycle → same 12 values as the gap-free run, no extra or missing valids.
- Back-to-back frames:
  - Drive pixels during mesgul_o → ignored.
  - Frame 2 loads box filter/shift 3 on its first pixel → frame 2 results use the new filter.
  - A filtre_etkin_i pulse mid-frame-2 → no effect.
- Reset: assert rstn_i low asynchronously after 5 pixels → veri_etkin_o and mesgul_o drop immediately. A fresh ramp frame after reset → correct 12 identity outputs, with no stale data.
